// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port (ALU vs load writeback).
// Define RF_WB_BYPASS_EN to forward the pending write to the two decode read ports.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              rf_hold,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              last_grant,
    output logic [CNT_W-1:0]  conflict_cnt,
    input  logic [ADDR_W-1:0] byp_raddr1,
    input  logic [ADDR_W-1:0] byp_raddr2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [DATA_W-1:0] byp_data1,
    output logic [DATA_W-1:0] byp_data2
);

    logic              grant_alu;
    logic              grant_mem;
    logic              both_vld;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Under contention the source that did not win last time is granted.
    always_comb begin
        both_vld  = alu_valid & mem_valid;
        grant_alu = ~rf_hold & alu_valid & (~mem_valid | last_grant);
        grant_mem = ~rf_hold & mem_valid & (~alu_valid | ~last_grant);
        xfer      = grant_alu | grant_mem;
        sel_addr  = grant_alu ? alu_addr : mem_addr;
        sel_data  = grant_alu ? alu_data : mem_data;
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    // Write-port register stage: r0 writes are accepted but never strobed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en     <= 1'b0;
            rf_wr_addr   <= '0;
            rf_wr_data   <= '0;
            last_grant   <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            rf_wr_en <= xfer && (sel_addr != '0);
            if (xfer) begin
                rf_wr_addr <= sel_addr;
                rf_wr_data <= sel_data;
                last_grant <= grant_mem;
            end
            if (both_vld) begin
                conflict_cnt <= sat_inc(conflict_cnt);
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    always_comb begin
        byp_hit1  = rf_wr_en && (rf_wr_addr == byp_raddr1) && (byp_raddr1 != '0);
        byp_hit2  = rf_wr_en && (rf_wr_addr == byp_raddr2) && (byp_raddr2 != '0);
        byp_data1 = byp_hit1 ? rf_wr_data : '0;
        byp_data2 = byp_hit2 ? rf_wr_data : '0;
    end
`else
    logic unused_byp;
    assign unused_byp = ^{byp_raddr1, byp_raddr2};
    assign byp_hit1   = 1'b0;
    assign byp_hit2   = 1'b0;
    assign byp_data1  = '0;
    assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios followed by randomized traffic.
module tb_rf_wb_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int SCW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0, mem_valid = 1'b0, rf_hold = 1'b0;
    logic [AW-1:0] alu_addr = '0, mem_addr = '0, byp_raddr1 = '0, byp_raddr2 = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;

    logic          alu_ready, mem_ready, rf_wr_en, last_grant, byp_hit1, byp_hit2;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data, byp_data1, byp_data2;
    logic [CW-1:0] conflict_cnt;

    logic           s_alu_ready, s_mem_ready, s_rf_wr_en, s_last_grant, s_byp_hit1, s_byp_hit2;
    logic [AW-1:0]  s_rf_wr_addr;
    logic [DW-1:0]  s_rf_wr_data, s_byp_data1, s_byp_data2;
    logic [SCW-1:0] s_conflict_cnt;

    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .rf_hold(rf_hold), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .last_grant(last_grant), .conflict_cnt(conflict_cnt),
        .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    // Narrow-counter twin sharing all inputs, so saturation is reachable quickly.
    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(SCW)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(s_alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(s_mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .rf_hold(rf_hold), .rf_wr_en(s_rf_wr_en), .rf_wr_addr(s_rf_wr_addr), .rf_wr_data(s_rf_wr_data),
        .last_grant(s_last_grant), .conflict_cnt(s_conflict_cnt),
        .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
        .byp_hit1(s_byp_hit1), .byp_hit2(s_byp_hit2), .byp_data1(s_byp_data1), .byp_data2(s_byp_data2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int  total = 0;
    int  bad = 0;
    wr_t exp_q[$];
    bit  mon_en = 1'b0;

    // Reference model: what the write port should hold, who won last, how many conflicts.
    bit            m_last;
    int unsigned   m_conf;
    bit            m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sat(input int unsigned v, input int w);
        int unsigned mx;
        mx = (32'd1 << w) - 1;
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    function automatic bit exp_hit(input logic [AW-1:0] r);
`ifdef RF_WB_BYPASS_EN
        return m_wen && (m_waddr == r) && (r != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_last  = 1'b1;
        m_conf  = 0;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        exp_q.delete();
    endtask

    // One clock: drive at the falling edge, check readies/bypass, model the rising edge.
    task automatic cycle(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                         input bit hold, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         output bit won_a, output bit won_m);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        rf_hold = hold; byp_raddr1 = r1; byp_raddr2 = r2;
        #1;
        won_a = 1'b0;
        won_m = 1'b0;
        if (!hold) begin
            if (av && mv) begin
                if (m_last) won_a = 1'b1;
                else        won_m = 1'b1;
            end else begin
                won_a = av;
                won_m = mv;
            end
        end
        chk("alu_ready", alu_ready, won_a);
        chk("mem_ready", mem_ready, won_m);
        chk("byp_hit1", byp_hit1, exp_hit(r1));
        chk("byp_hit2", byp_hit2, exp_hit(r2));
        chk("byp_data1", byp_data1, exp_hit(r1) ? m_wdata : '0);
        chk("byp_data2", byp_data2, exp_hit(r2) ? m_wdata : '0);
        if (won_a || won_m) begin
            m_last  = won_m;
            m_waddr = won_a ? aa : ma;
            m_wdata = won_a ? ad : md;
            m_wen   = (m_waddr != 0);
            if (m_wen) exp_q.push_back('{a: m_waddr, d: m_wdata});
        end else begin
            m_wen = 1'b0;
        end
        if (av && mv) m_conf++;
        @(negedge clk);
        chk("rf_wr_en", rf_wr_en, m_wen);
        chk("last_grant", last_grant, m_last);
        chk("conflict_cnt", conflict_cnt, sat(m_conf, CW));
        chk("conflict_cnt_sat", s_conflict_cnt, sat(m_conf, SCW));
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0; rf_hold = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_wr_en", rf_wr_en, 1'b0);
        chk("rst_wr_addr", rf_wr_addr, '0);
        chk("rst_wr_data", rf_wr_data, '0);
        chk("rst_last_grant", last_grant, 1'b1);
        chk("rst_conflict", conflict_cnt, '0);
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    wr_t mon_e;
    always @(negedge clk) begin
        if (mon_en && rst_n && rf_wr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", rf_wr_addr, rf_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", rf_wr_addr, mon_e.a);
                chk("wr_data", rf_wr_data, mon_e.d);
            end
        end
    end

    initial begin
        bit ga, gm;
        bit pa, pm;
        logic [AW-1:0] qa, qm;
        logic [DW-1:0] da, dm;

        @(negedge clk);
        do_reset();

        // Single ALU write, then idle.
        cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, ga, gm);
        chk("alu1_ready", ga, 1'b1);
        chk("alu1_wr_en", rf_wr_en, 1'b1);
        chk("alu1_wr_addr", rf_wr_addr, 5);
        chk("alu1_wr_data", rf_wr_data, 32'h1234);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        chk("alu1_idle_wr_en", rf_wr_en, 1'b0);
        chk("idle_hold_addr", rf_wr_addr, 5);

        // Load to r0: accepted, no strobe.
        cycle(0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, ga, gm);
        chk("r0_ready", gm, 1'b1);
        chk("r0_wr_en", rf_wr_en, 1'b0);
        chk("r0_last", last_grant, 1'b1);

        // Continuous contention alternates ALU, MEM, ALU, MEM.
        for (int i = 0; i < 4; i++) begin
            cycle(1, 3, 32'hA, 1, 7, 32'hB, 0, 0, 0, ga, gm);
            chk("alt_wr_addr", rf_wr_addr, (i % 2 == 0) ? 3 : 7);
        end
        chk("alt_conflict", conflict_cnt, 4);

        // Hold blocks everything but still counts conflicts.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 3, 32'hA, 1, 7, 32'hB, 1, 0, 0, ga, gm);
            chk("hold_wr_en", rf_wr_en, 1'b0);
        end
        chk("hold_conflict", conflict_cnt, 7);
        cycle(1, 3, 32'hA, 1, 7, 32'hB, 0, 0, 0, ga, gm);
        chk("release_alu_first", ga, 1'b1);
        chk("sat_small", s_conflict_cnt, 8);
        for (int i = 0; i < 10; i++) cycle(1, 3, 32'hA, 1, 7, 32'hB, 1, 0, 0, ga, gm);
        chk("sat_small_max", s_conflict_cnt, 15);

        // Forwarding of an in-flight write.
        cycle(1, 9, 32'h55, 0, 0, 0, 0, 0, 0, ga, gm);
        cycle(0, 0, 0, 0, 0, 0, 0, 9, 0, ga, gm);

        // Reset while a write strobe is up.
        cycle(1, 12, 32'hCAFE, 0, 0, 0, 0, 0, 0, ga, gm);
        chk("pre_rst_wr_en", rf_wr_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", rf_wr_en, 1'b0);
        chk("async_rst_last", last_grant, 1'b1);
        chk("async_rst_conflict", conflict_cnt, '0);
        @(negedge clk);
        do_reset();

        // Randomized traffic; sources hold their request until accepted.
        pa = 0; pm = 0; qa = '0; qm = '0; da = '0; dm = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!pa && ($urandom % 2 == 0)) begin
                pa = 1; qa = AW'($urandom_range(0, 31)); da = $urandom;
            end
            if (!pm && ($urandom % 2 == 0)) begin
                pm = 1; qm = AW'($urandom_range(0, 31)); dm = $urandom;
            end
            cycle(pa, qa, da, pm, qm, dm, ($urandom % 5 == 0),
                  AW'($urandom_range(0, 31)), (n % 3 == 0) ? rf_wr_addr : AW'($urandom_range(0, 31)),
                  ga, gm);
            if (ga) pa = 0;
            if (gm) pm = 0;
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL wr_missing: got %0d writes outstanding expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences the register file's single write port (addr3/data3) between the two writeback sources of the 32-bit MIPS datapath: the ALU result path and the load (memory) path.
- Uses round-robin arbitration with a valid/ready handshake per source.
- Registers the granted write onto the register-file write port, drops writes to r0, and counts contention cycles.

Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address (32 registers)
- CNT_W, 16, width of saturating conflict counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load writeback request
- mem_ready  out  1  load request accepted this cycle
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- rf_hold  in  1  write port blocked; accept nothing
- rf_wr_en  out  1  register-file write strobe
- rf_wr_addr  out  ADDR_W  register-file write address
- rf_wr_data  out  DATA_W  register-file write data
- last_grant  out  1  0 = ALU last granted, 1 = MEM last granted
- conflict_cnt  out  CNT_W  saturating count of cycles with both valid

Behaviour:
- Reset (async on rst_n low, released synchronously at the next clk edge):
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, conflict_cnt=0.
  - last_grant=1, so ALU wins the first conflict.
- Grant (combinational):
  - rf_hold=1 -> alu_ready=mem_ready=0.
  - Otherwise, only one source valid -> that source granted.
  - Both valid -> the source NOT equal to last_grant is granted.
  - At most one ready high per cycle; ready never high without its valid.
- Transfer: valid&ready at edge N.
  - Registers addr/data into rf_wr_addr/rf_wr_data at edge N.
  - rf_wr_en is high for exactly the following cycle (latency 1).
  - last_grant updates to the granted source at the same edge.
- r0 rule: a transfer with addr==0 is accepted (ready high, last_grant updates), but rf_wr_en stays 0 for that cycle; rf_wr_addr/rf_wr_data still update.
- No transfer in a cycle (idle or rf_hold) -> rf_wr_en=0 next cycle; rf_wr_addr/rf_wr_data hold their previous values.
- Back-to-back: with rf_hold=0, one transfer per cycle is sustained. Alternating grants under continuous dual valid.
- Source rule: valid/addr/data are held stable until ready. Dropping valid before ready is a source error; the arbiter simply re-evaluates each cycle.
- conflict_cnt:
  - Increments on each clk edge where alu_valid&mem_valid, regardless of rf_hold.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by reset.
- Reset asserted mid-stream: outputs clear immediately (async); any in-flight registered write is lost, with no write strobe emitted.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Added ports (always present):
  - byp_raddr1/byp_raddr2  in  ADDR_W
  - byp_hit1/byp_hit2  out  1
  - byp_data1/byp_data2  out  DATA_W
- Defined:
  - byp_hitK = rf_wr_en & (rf_wr_addr==byp_raddrK) & (byp_raddrK!=0), combinational.
  - byp_dataK = rf_wr_data when hit, else 0.
  - Lets decode forward a value being written this cycle.
- Undefined: byp_hitK=0 and byp_dataK=0 constantly; inputs ignored.

Test Plan:
- Reset then idle -> rf_wr_en=0, conflict_cnt=0, last_grant=1; assert rst_n low mid-write (rf_wr_en=1) -> rf_wr_en drops to 0 without a clk edge.
- alu_valid=1, alu_addr=5, alu_data=0x1234 for one cycle -> alu_ready=1 that cycle; next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0x1234; following cycle rf_wr_en=0.
- Both valid for 4 cycles (ALU addr 3 / data 0xA, MEM addr 7 / data 0xB, each re-presented after acceptance) -> write order ALU, MEM, ALU, MEM, one per cycle; conflict_cnt=4.
- mem_valid=1, mem_addr=0, mem_data=0xFFFF -> mem_ready=1, rf_wr_en stays 0, last_grant=1.
- rf_hold=1 for 3 cycles with both valid -> no readies, rf_wr_en=0, conflict_cnt=3; release -> ALU granted first; force conflict_cnt near max -> saturates at 0xFFFF.
- With RF_WB_BYPASS_EN: write addr 9 data 0x55 in flight, byp_raddr1=9, byp_raddr2=0 -> byp_hit1=1, byp_data1=0x55, byp_hit2=0; without the macro both hits are 0.
